// File: rtl/pcpu_ctrl_pkg.sv
// Shared constants for the pipelined-CPU run controller: state encodings and default widths.
package pcpu_ctrl_pkg;

   localparam logic [1:0] ST_STOP = 2'b00;
   localparam logic [1:0] ST_STEP = 2'b01;
   localparam logic [1:0] ST_RUN  = 2'b10;
   localparam logic [1:0] ST_HALT = 2'b11;

   localparam int DEF_DB_CYCLES = 16;
   localparam int DEF_PC_W      = 8;
   localparam int DEF_STEP_W    = 8;

endpackage

// File: rtl/pcpu_run_controller_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce counter and rising-edge press pulse.
module btn_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_press
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   logic             r_sync0;
   logic             r_sync1;
   logic             r_level;
   logic             r_level_d;
   logic [CNT_W-1:0] r_cnt;

   // The accepted level only flips after DB_CYCLES consecutive synchronized samples disagree with it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync0   <= 1'b0;
         r_sync1   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync0   <= i_btn;
         r_sync1   <= r_sync0;
         r_level_d <= r_level;
         if (r_sync1 != r_level) begin
            if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
               r_level <= r_sync1;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/pcpu_run_controller.sv
// Run/step/breakpoint sequencer for the 5-stage CPU; the only source of the CPU-wide clock enable.
module pcpu_run_controller
   import pcpu_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES,
   parameter int PC_W      = DEF_PC_W,
   parameter int STEP_W    = DEF_STEP_W
) (
   input  logic              myclk,
   input  logic              reset,
   input  logic              btn_step,
   input  logic              btn_run,
   input  logic [STEP_W-1:0] step_count,
   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_addr,
   input  logic [PC_W-1:0]   pc,
   input  logic              cpu_halted,
   output logic              cpu_en,
   output logic              bp_hit,
   output logic [1:0]        state_o,
   output logic              busy
);

   logic              w_step_press;
   logic              w_run_press;
   logic              w_active;
   logic              w_bp_match;
   logic [1:0]        w_state_nxt;
   logic [STEP_W-1:0] w_cnt_nxt;
   logic              w_skip_nxt;

   logic [1:0]        r_state;
   logic [STEP_W-1:0] r_cnt;
   logic              r_skip;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
      .i_clk   (myclk),
      .i_rst_n (reset),
      .i_btn   (btn_step),
      .o_press (w_step_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
      .i_clk   (myclk),
      .i_rst_n (reset),
      .i_btn   (btn_run),
      .o_press (w_run_press)
   );

   // The skip flag masks the breakpoint for the first enabled cycle so a resume executes past it.
   always_comb begin
      w_active   = (r_state == ST_STEP) || (r_state == ST_RUN);
      w_bp_match = bp_en && (pc == bp_addr) && !r_skip;
      cpu_en     = w_active && !w_bp_match && !cpu_halted;
      bp_hit     = w_active && w_bp_match && !cpu_halted;
      state_o    = r_state;
      busy       = w_active;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_skip_nxt  = cpu_en ? 1'b0 : r_skip;
      case (r_state)
         ST_STOP: begin
            if (cpu_halted) begin
               w_state_nxt = ST_HALT;
            end else if (w_run_press) begin
               w_state_nxt = ST_RUN;
               w_skip_nxt  = 1'b1;
            end else if (w_step_press) begin
               w_state_nxt = ST_STEP;
               w_cnt_nxt   = (step_count == '0) ? STEP_W'(1) : step_count;
               w_skip_nxt  = 1'b1;
            end
         end
         ST_STEP: begin
            if (cpu_halted) begin
               w_state_nxt = ST_HALT;
            end else if (w_bp_match || w_run_press) begin
               w_state_nxt = ST_STOP;
               w_cnt_nxt   = '0;
            end else if (r_cnt == STEP_W'(1)) begin
               w_state_nxt = ST_STOP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_RUN: begin
            if (cpu_halted) begin
               w_state_nxt = ST_HALT;
            end else if (w_bp_match || w_run_press) begin
               w_state_nxt = ST_STOP;
            end
         end
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_STOP;
      endcase
   end

   always_ff @(posedge myclk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_STOP;
         r_cnt   <= '0;
         r_skip  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_skip  <= w_skip_nxt;
      end
   end

endmodule

// File: tb/tb_pcpu_run_controller.sv
// Bench for pcpu_run_controller: directed scenarios plus random button/breakpoint/halt traffic.
module tb_pcpu_run_controller;

   localparam int DB = 4;

   logic       myclk = 1'b0;
   logic       reset;
   logic       btn_step;
   logic       btn_run;
   logic [7:0] step_count;
   logic       bp_en;
   logic [7:0] bp_addr;
   logic [7:0] pc;
   logic       cpu_halted;
   logic       cpu_en;
   logic       bp_hit;
   logic [1:0] state_o;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int en_cnt  = 0;
   int hit_cnt = 0;

   logic [4:0] exp_q[$];

   pcpu_run_controller #(.DB_CYCLES(DB), .PC_W(8), .STEP_W(8)) dut (
      .myclk      (myclk),
      .reset      (reset),
      .btn_step   (btn_step),
      .btn_run    (btn_run),
      .step_count (step_count),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .pc         (pc),
      .cpu_halted (cpu_halted),
      .cpu_en     (cpu_en),
      .bp_hit     (bp_hit),
      .state_o    (state_o),
      .busy       (busy)
   );

   always #5 myclk = ~myclk;

   // Reference model: mode 0 stopped, 1 stepping, 2 running, 3 halted.
   int m_mode = 0;
   int m_left = 0;
   bit m_skip = 0;
   bit m_lvl_s = 0, m_lvl_s_d = 0, m_lvl_r = 0, m_lvl_r_d = 0;
   bit hist_s[$];
   bit hist_r[$];
   bit last_en = 0;

   function automatic bit window_differs(input bit q[$], input bit lvl);
      for (int i = 1; i <= DB; i++) if (q[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_hist();
      hist_s.delete();
      hist_r.delete();
      for (int i = 0; i < DB + 2; i++) begin
         hist_s.push_back(1'b0);
         hist_r.push_back(1'b0);
      end
   endtask

   task automatic model_step();
      bit ps, pr, active, match, en, hit, nl;
      if (!reset) begin
         m_mode = 0; m_left = 0; m_skip = 0;
         m_lvl_s = 0; m_lvl_s_d = 0; m_lvl_r = 0; m_lvl_r_d = 0;
         clear_hist();
         exp_q.push_back(5'b0);
         last_en = 0;
         return;
      end
      ps     = m_lvl_s && !m_lvl_s_d;
      pr     = m_lvl_r && !m_lvl_r_d;
      active = (m_mode == 1) || (m_mode == 2);
      match  = bp_en && (pc == bp_addr) && !m_skip;
      en     = active && !match && !cpu_halted;
      hit    = active && match && !cpu_halted;
      exp_q.push_back({2'(m_mode), en, hit, active});
      last_en = en;
      if (en) m_skip = 0;
      case (m_mode)
         0: if (cpu_halted) m_mode = 3;
            else if (pr) begin m_mode = 2; m_skip = 1; end
            else if (ps) begin
               m_mode = 1; m_skip = 1;
               m_left = (step_count == 0) ? 1 : int'(step_count);
            end
         1: if (cpu_halted) m_mode = 3;
            else if (match || pr) m_mode = 0;
            else begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = 0;
            end
         2: if (cpu_halted) m_mode = 3;
            else if (match || pr) m_mode = 0;
         default: m_mode = 3;
      endcase
      nl = window_differs(hist_s, m_lvl_s) ? hist_s[1] : m_lvl_s;
      m_lvl_s_d = m_lvl_s; m_lvl_s = nl;
      nl = window_differs(hist_r, m_lvl_r) ? hist_r[1] : m_lvl_r;
      m_lvl_r_d = m_lvl_r; m_lvl_r = nl;
      hist_s.push_front(btn_step); void'(hist_s.pop_back());
      hist_r.push_front(btn_run);  void'(hist_r.pop_back());
   endtask

   // The attached CPU fetches sequentially whenever it is enabled.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(negedge myclk);
         if (last_en) pc = pc + 8'd1;
      end
   endtask

   task automatic press(input bit do_step, input bit do_run, input int hold);
      btn_step = do_step;
      btn_run  = do_run;
      tick(hold);
      btn_step = 1'b0;
      btn_run  = 1'b0;
      tick(DB + 4);
   endtask

   task automatic chk(input string name, input bit ok, input int got, input string req);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %s", name, got, req);
      end
   endtask

   initial begin : monitor
      logic [4:0] e;
      logic [4:0] g;
      forever begin
         @(negedge myclk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {state_o, cpu_en, bp_hit, busy};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL cycle_check t=%0t: got st=%b en=%b hit=%b busy=%b, expected st=%b en=%b hit=%b busy=%b",
                        $time, g[4:3], g[2], g[1], g[0], e[4:3], e[2], e[1], e[0]);
            end
            if (cpu_en === 1'b1) en_cnt++;
            if (bp_hit === 1'b1) hit_cnt++;
         end
      end
   end

   initial begin : driver
      int base, hbase, r;
      reset = 1'b0; btn_step = 1'b0; btn_run = 1'b0; step_count = 8'd1;
      bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00; cpu_halted = 1'b0;
      clear_hist();
      @(negedge myclk);
      tick(3);
      reset = 1'b1;
      tick(4);

      step_count = 8'd3;
      base = en_cnt;
      press(1, 0, 8); tick(10);
      chk("step_burst_3", en_cnt - base == 3, en_cnt - base, "3");
      step_count = 8'd0;
      base = en_cnt;
      press(1, 0, 8); tick(10);
      chk("step_burst_0_as_1", en_cnt - base == 1, en_cnt - base, "1");

      press(0, 1, 8);
      tick(3);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      base = en_cnt;
      tick(20);
      chk("no_press_after_reset", en_cnt - base == 0, en_cnt - base, "0");

      step_count = 8'd2;
      base = en_cnt;
      btn_step = 1'b1; tick(2); btn_step = 1'b0; tick(12);
      chk("glitch_ignored", en_cnt - base == 0, en_cnt - base, "0");
      base = en_cnt;
      press(1, 0, 20); tick(6);
      chk("held_one_burst", en_cnt - base == 2, en_cnt - base, "2");

      bp_en = 1'b1; bp_addr = 8'h10; pc = 8'h08;
      hbase = hit_cnt;
      press(0, 1, 8); tick(6);
      chk("bp_hit_once", hit_cnt - hbase == 1, hit_cnt - hbase, "1");
      chk("bp_pc_held", pc == 8'h10, int'(pc), "16");
      base = en_cnt;
      press(0, 1, 8);
      chk("resume_past_bp", en_cnt - base >= 5, en_cnt - base, ">=5");
      chk("resume_no_rehit", hit_cnt - hbase == 1, hit_cnt - hbase, "1");
      bp_en = 1'b0;
      press(0, 1, 8); tick(4);

      base = en_cnt;
      press(1, 1, 8); tick(10);
      chk("run_wins_tie", en_cnt - base >= 15, en_cnt - base, ">=15");
      press(0, 1, 8);
      step_count = 8'd40;
      base = en_cnt;
      press(1, 0, 8);
      press(0, 1, 8); tick(4);
      chk("run_aborts_step", (en_cnt - base > 0) && (en_cnt - base < 40), en_cnt - base, "1..39");

      press(0, 1, 8);
      tick(3);
      cpu_halted = 1'b1;
      tick(2);
      base = en_cnt;
      press(1, 0, 8);
      press(0, 1, 8);
      chk("halt_sticky", en_cnt - base == 0, en_cnt - base, "0");
      reset = 1'b0; tick(2);
      cpu_halted = 1'b0; reset = 1'b1;
      tick(3);

      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: press(0, 1, $urandom_range(4, 12));
            3, 4: begin
               step_count = 8'($urandom_range(0, 6));
               press(1, 0, $urandom_range(4, 12));
            end
            5: press(1, 1, $urandom_range(4, 10));
            6: begin
               if ($urandom_range(0, 1) == 0) btn_step = 1'b1; else btn_run = 1'b1;
               tick($urandom_range(1, 3));
               btn_step = 1'b0; btn_run = 1'b0;
               tick($urandom_range(2, 8));
            end
            7: begin
               bp_en   = 1'($urandom_range(0, 1));
               bp_addr = pc + 8'($urandom_range(0, 12));
               tick($urandom_range(1, 10));
            end
            8: begin
               reset = 1'b0; tick($urandom_range(1, 2)); reset = 1'b1;
               tick($urandom_range(1, 4));
            end
            default: begin
               if ($urandom_range(0, 4) == 0) begin
                  cpu_halted = 1'b1; tick(5);
                  press(0, 1, 6);
                  reset = 1'b0; tick(1);
                  cpu_halted = 1'b0; reset = 1'b1;
               end
               tick($urandom_range(1, 15));
            end
         endcase
      end

      tick(4);
      #5;
      chk("queue_drained", exp_q.size() == 0, exp_q.size(), "0");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
